seg_scan_capture: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 46 ++++
 rtl/seg_scan_capture_if.sv | 30 +++
 rtl/seg_symbol_decode.sv | 23 ++
 rtl/seg_scan_capture.sv | 132 +++++++++++++
 tb/tb_seg_scan_capture.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
// Shared symbol codes, segment patterns and anode encodings for the
// seven-segment display capture/drive blocks.
package seg_scan_pkg;

  typedef logic [4:0] sym_t;

  localparam sym_t SYM_BLANK = 5'd0;
  localparam sym_t SYM_P     = 5'd17;
  localparam sym_t SYM_L     = 5'd18;
  localparam sym_t SYM_H     = 5'd19;
  localparam sym_t SYM_DASH  = 5'd20;
  localparam sym_t SYM_BAD   = 5'd31;

  // Active-low abcdefg patterns; bit6 = a, bit0 = g.
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_P    = 7'b0011000;
  localparam logic [6:0] SEG_L    = 7'b1110001;
  localparam logic [6:0] SEG_H    = 7'b1001000;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  // Entry n is the pattern for hex value n (symbol code n+1).
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  localparam logic [3:0] AN_D0   = 4'b1110;
  localparam logic [3:0] AN_D1   = 4'b1101;
  localparam logic [3:0] AN_D2   = 4'b1011;
  localparam logic [3:0] AN_D3   = 4'b0111;
  localparam logic [3:0] AN_IDLE = 4'b1111;

  function automatic logic an_one_cold(logic [3:0] an_n);
    return $countones(~an_n) == 1;
  endfunction

  function automatic logic [1:0] an_index(logic [3:0] an_n);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) if (!an_n[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Display lines into the capture block and reconstructed digits out.
// order_error exists only when SCAN_ORDER_CHECK_EN is defined.
interface seg_scan_capture_if;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic [19:0] digits;
  logic        digits_valid;
  logic        update;
  logic        bad_pattern;
  logic        link_lost;
`ifdef SCAN_ORDER_CHECK_EN
  logic        order_error;
`endif

  modport master (
    output an_n, seg_n,
    input  digits, digits_valid, update, bad_pattern, link_lost
`ifdef SCAN_ORDER_CHECK_EN
    , input order_error
`endif
  );

  modport slave (
    input  an_n, seg_n,
    output digits, digits_valid, update, bad_pattern, link_lost
`ifdef SCAN_ORDER_CHECK_EN
    , output order_error
`endif
  );
endinterface

// File: rtl/seg_symbol_decode.sv
// Combinational active-low segment pattern to game symbol code lookup.
module seg_symbol_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output sym_t       code_o,
  output logic       bad_o
);
  always_comb begin
    code_o = SYM_BAD;
    case (seg_n_i)
      SEG_OFF:  code_o = SYM_BLANK;
      SEG_P:    code_o = SYM_P;
      SEG_L:    code_o = SYM_L;
      SEG_H:    code_o = SYM_H;
      SEG_DASH: code_o = SYM_DASH;
      default:  code_o = SYM_BAD;
    endcase
    for (int h = 0; h < 16; h++)
      if (seg_n_i == SEG_HEX[h]) code_o = sym_t'(h + 1);
    bad_o = (code_o == SYM_BAD);
  end
endmodule

// File: rtl/seg_scan_capture.sv
// Captures a scanning 4-digit seven-segment display back into symbol codes,
// with per-digit debounce and link timeout. Optional: SCAN_ORDER_CHECK_EN.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int CONFIRM       = 3,
  parameter int TIMEOUT       = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_capture_if.slave  bus
);
  localparam int         NUM_DIG = 4;
  localparam logic [2:0] CONF    = 3'(CONFIRM);

  logic [3:0]       an_s1_q, an_s2_q, an_prev_q;
  logic [6:0]       seg_s1_q, seg_s2_q;
  logic [CNT_W-1:0] dwell_q, dwell_d, to_q, to_d;
  logic             sample, expire;
  logic [1:0]       idx;
  sym_t             code;
  logic             code_bad;

  logic [NUM_DIG-1:0][4:0] cand_q, cand_d, com_q, com_d;
  logic [NUM_DIG-1:0][2:0] agree_q, agree_d;
  logic [NUM_DIG-1:0]      seen_q, seen_d;
  logic                    chg;
  logic                    link_lost_q, link_lost_d, update_q, update_d;

  seg_symbol_decode u_dec (.seg_n_i(seg_s2_q), .code_o(code), .bad_o(code_bad));

  assign idx = an_index(an_s2_q);

  // One sample per anode visit: dwell saturates past the settle point.
  always_comb begin
    dwell_d = dwell_q;
    if (an_s2_q != an_prev_q)      dwell_d = '0;
    else if (dwell_q != '1)        dwell_d = dwell_q + CNT_W'(1);
    sample = (an_s2_q == an_prev_q) && (dwell_q == CNT_W'(SETTLE_CYCLES - 1))
             && an_one_cold(an_s2_q);
    expire = !sample && (to_q == CNT_W'(TIMEOUT - 1));
    to_d   = sample ? '0 : (expire ? to_q : to_q + CNT_W'(1));
    link_lost_d = sample ? 1'b0 : (expire ? 1'b1 : link_lost_q);
  end

  always_comb begin
    cand_d  = cand_q;
    agree_d = agree_q;
    com_d   = com_q;
    seen_d  = seen_q;
    chg     = 1'b0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (sample && idx == 2'(i)) begin
        if (code == cand_q[i]) begin
          if (agree_q[i] != CONF) agree_d[i] = agree_q[i] + 3'd1;
        end else begin
          cand_d[i]  = code;
          agree_d[i] = 3'd1;
        end
        if (agree_d[i] == CONF) begin
          chg       = (com_q[i] != code);
          com_d[i]  = code;
          seen_d[i] = 1'b1;
        end
      end else if (expire) begin
        agree_d[i] = '0;
        seen_d[i]  = 1'b0;
      end
    end
    update_d = (chg && (&seen_q)) || ((&seen_d) && !(&seen_q));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_s1_q     <= AN_IDLE;
      an_s2_q     <= AN_IDLE;
      an_prev_q   <= AN_IDLE;
      seg_s1_q    <= SEG_OFF;
      seg_s2_q    <= SEG_OFF;
      dwell_q     <= '0;
      to_q        <= '0;
      cand_q      <= '0;
      agree_q     <= '0;
      com_q       <= '0;
      seen_q      <= '0;
      link_lost_q <= 1'b0;
      update_q    <= 1'b0;
    end else begin
      an_s1_q     <= bus.an_n;
      an_s2_q     <= an_s1_q;
      an_prev_q   <= an_s2_q;
      seg_s1_q    <= bus.seg_n;
      seg_s2_q    <= seg_s1_q;
      dwell_q     <= dwell_d;
      to_q        <= to_d;
      cand_q      <= cand_d;
      agree_q     <= agree_d;
      com_q       <= com_d;
      seen_q      <= seen_d;
      link_lost_q <= link_lost_d;
      update_q    <= update_d;
    end
  end

  assign bus.digits       = com_q;
  assign bus.digits_valid = &seen_q;
  assign bus.update       = update_q;
  assign bus.bad_pattern  = sample && code_bad;
  assign bus.link_lost    = link_lost_q;

`ifdef SCAN_ORDER_CHECK_EN
  // Expected successor is idx+1 mod 4; resync to whatever was sampled.
  logic [1:0] last_q;
  logic       have_last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q      <= '0;
      have_last_q <= 1'b0;
    end else if (sample) begin
      last_q      <= idx;
      have_last_q <= 1'b1;
    end else if (expire) begin
      have_last_q <= 1'b0;
    end
  end

  assign bus.order_error = sample && have_last_q && (idx != last_q + 2'd1);
`endif
endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomized visit-level bench for seg_scan_capture with a per-visit
// behavioural model of debounce, publish, timeout and scan order.
module tb_seg_scan_capture;
  localparam int SETTLE = 16, CONF = 3, TMO = 3000, CW = 20, VISIT = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_capture_if bus();

  seg_scan_capture #(.SETTLE_CYCLES(SETTLE), .CONFIRM(CONF), .TIMEOUT(TMO), .CNT_W(CW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0, n_pass = 0;
  int upd_cnt = 0, bad_cnt = 0, ord_cnt = 0;
  int exp_upd = 0, exp_bad = 0, exp_ord = 0;
  int m_cand[4], m_agree[4], m_com[4];
  bit m_seen[4];
  bit m_lost, m_have;
  int m_last;
  int c[4];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.update)      upd_cnt++;
      if (bus.bad_pattern) bad_cnt++;
`ifdef SCAN_ORDER_CHECK_EN
      if (bus.order_error) ord_cnt++;
`endif
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [6:0] enc(int code);
    logic [6:0] on;
    case (code)
      0:  on = 7'b0000000;  1:  on = 7'b1111110;  2:  on = 7'b0110000;
      3:  on = 7'b1101101;  4:  on = 7'b1111001;  5:  on = 7'b0110011;
      6:  on = 7'b1011011;  7:  on = 7'b1011111;  8:  on = 7'b1110000;
      9:  on = 7'b1111111;  10: on = 7'b1111011;  11: on = 7'b1110111;
      12: on = 7'b0011111;  13: on = 7'b1001110;  14: on = 7'b0111101;
      15: on = 7'b1001111;  16: on = 7'b1000111;  17: on = 7'b1100111;
      18: on = 7'b0001110;  19: on = 7'b0110111;  20: on = 7'b0000001;
      default: on = ~7'b0101010;
    endcase
    return ~on;
  endfunction

  function automatic bit all_seen();
    return m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
  endfunction

  function automatic logic [19:0] m_dig();
    return {5'(m_com[3]), 5'(m_com[2]), 5'(m_com[1]), 5'(m_com[0])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cand[i] = 0; m_agree[i] = 0; m_com[i] = 0; m_seen[i] = 0;
    end
    m_lost = 0; m_have = 0; m_last = 0;
  endtask

  task automatic model_timeout();
    m_lost = 1; m_have = 0;
    for (int i = 0; i < 4; i++) begin m_agree[i] = 0; m_seen[i] = 0; end
  endtask

  task automatic model_sample(int d, int code);
    bit was_valid;
    was_valid = all_seen();
    m_lost = 0;
    if (code == 31) exp_bad++;
    if (m_have && d != (m_last + 1) % 4) exp_ord++;
    m_last = d; m_have = 1;
    if (code == m_cand[d]) begin
      if (m_agree[d] < CONF) m_agree[d]++;
    end else begin
      m_cand[d] = code; m_agree[d] = 1;
    end
    if (m_agree[d] == CONF) begin
      if (was_valid && m_com[d] != code) exp_upd++;
      m_com[d] = code; m_seen[d] = 1;
      if (!was_valid && all_seen()) exp_upd++;
    end
  endtask

  task automatic check_state(string tag);
    chk({tag, ".digits"}, bus.digits, m_dig());
    chk({tag, ".valid"},  bus.digits_valid, all_seen());
    chk({tag, ".lost"},   bus.link_lost, m_lost);
    chk({tag, ".updcnt"}, upd_cnt, exp_upd);
    chk({tag, ".badcnt"}, bad_cnt, exp_bad);
`ifdef SCAN_ORDER_CHECK_EN
    chk({tag, ".ordcnt"}, ord_cnt, exp_ord);
`endif
  endtask

  task automatic visit(string tag, int d, int code);
    logic [3:0] one;
    one = 4'b0001;
    bus.an_n  = ~(one << d);
    bus.seg_n = enc(code);
    repeat (VISIT) @(negedge clk);
    #1;
    model_sample(d, code);
    check_state($sformatf("%s.d%0d", tag, d));
  endtask

  task automatic scan(string tag, int rounds);
    for (int r = 0; r < rounds; r++) begin
      visit(tag, 1, c[1]); visit(tag, 2, c[2]);
      visit(tag, 3, c[3]); visit(tag, 0, c[0]);
    end
  endtask

  initial begin
    bus.an_n = 4'b1111; bus.seg_n = 7'b1111111;
    model_reset();
    repeat (4) @(negedge clk);
    #1;
    check_state("rst");
    chk("rst.update", bus.update, 1'b0);
    chk("rst.bad", bus.bad_pattern, 1'b0);
    rst_n = 1'b1;

    c[0] = 2; c[1] = 0; c[2] = 18; c[3] = 17;
    scan("fill", 3);
    chk("fill.onepulse", upd_cnt, 1);
    chk("fill.valid", bus.digits_valid, 1'b1);

    c[0] = 10;
    scan("chg", 3);

    for (int r = 0; r < 4; r++) begin
      c[2] = (r % 2 == 0) ? 19 : 18;
      scan("alt", 1);
    end
    c[2] = 18;

    c[3] = 31;
    scan("bad", 3);

    for (int r = 0; r < 20; r++) begin
      for (int d = 0; d < 4; d++)
        if ($urandom_range(0, 3) == 0)
          c[d] = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 20));
      scan("rnd", 1);
    end

    bus.an_n = 4'b1111;
    repeat (TMO + 50) @(negedge clk);
    #1;
    model_timeout();
    check_state("tmo");
    scan("resume", 3);

    bus.an_n = 4'b1101; bus.seg_n = enc(c[1]);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    model_reset();
    check_state("mrst");
    rst_n = 1'b1;
    scan("after", 3);

`ifdef SCAN_ORDER_CHECK_EN
    visit("ord", 1, c[1]); visit("ord", 3, c[3]);
    visit("ord", 2, c[2]); visit("ord", 0, c[0]);
    scan("ordok", 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
